// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM encoding, flag layout.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_W    = 3;

  function automatic logic is_mul_op(input logic [3:0] op, input int mul_en);
    return (mul_en != 0) && (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// done pulses for one cycle once the full 2*WIDTH product is in the accumulator.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             hi_nz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign prod_lo = acc_q[WIDTH-1:0];
  assign hi_nz   = |acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU: single-cycle ops at full throughput, optional iterative MUL
// that blocks the input until its result has been handed off.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Cout,
  output logic             zero,
  output logic             ovf
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;

  logic               accept, out_xfer;
  logic               mul_start, mul_done, mul_hi_nz;
  logic [WIDTH-1:0]   mul_lo;

  logic [WIDTH:0]     sum_ext, dif_ext, shl_ext, shr_ext;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_o;

  // Held at 0 during reset so nothing can be accepted before release.
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    shamt   = B[SW-1:0];
    sum_ext = {1'b0, A} + {1'b0, B};
    dif_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    // Extra bit on the shifted-out side catches the last bit that left the word.
    shl_ext = {1'b0, A} << shamt;
    shr_ext = {A, 1'b0} >> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (sel)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_o   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_o   = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NAND: alu_res = ~(A & B);
      OP_NOR:  alu_res = ~(A | B);
      OP_XNOR: alu_res = ~(A ^ B);
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (is_mul_op(sel, MUL_EN)) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            out_valid_d         = 1'b1;
            result_d            = alu_res;
            flags_d             = '0;
            flags_d[FLAG_COUT]  = alu_c;
            flags_d[FLAG_ZERO]  = (alu_res == '0);
            flags_d[FLAG_OVF]   = alu_o;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          out_valid_d         = 1'b1;
          result_d            = mul_lo;
          flags_d             = '0;
          flags_d[FLAG_COUT]  = mul_hi_nz;
          flags_d[FLAG_ZERO]  = (mul_lo == '0);
          state_d             = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .prod_lo (mul_lo),
        .hi_nz   (mul_hi_nz)
      );
    end else begin : g_no_mul
      assign mul_done  = 1'b0;
      assign mul_lo    = '0;
      assign mul_hi_nz = 1'b0;
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign Cout      = flags_q[FLAG_COUT];
  assign zero      = flags_q[FLAG_ZERO];
  assign ovf       = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed 4-bit vectors plus an 8-bit scoreboard run.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] A, B, result;
  logic [3:0] sel;
  logic       Cout, zero, ovf;

  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] a4, b4, res4, sel4;
  logic       c4, z4, o4;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  int   xfer_cyc[$];

  alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .Cout(Cout), .zero(zero), .ovf(ovf)
  );

  alu_pipe #(.WIDTH(4), .MUL_EN(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .sel(sel4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(res4), .Cout(c4), .zero(z4), .ovf(o4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, t, n;
    e  = '0;
    ua = int'(a);
    ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    n  = ub % 8;
    case (op)
      4'd0: begin t = ua + ub; e.res = t[7:0]; e.c = (t > 255);
                  t = sa + sb; e.o = (t > 127) || (t < -128); end
      4'd1: begin t = ua - ub; e.res = t[7:0]; e.c = (ua >= ub);
                  t = sa - sb; e.o = (t > 127) || (t < -128); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ~(a & b);
      4'd6: e.res = ~(a | b);
      4'd7: e.res = ~(a ^ b);
      4'd8: begin t = ua << n; e.res = t[7:0]; e.c = (n == 0) ? 1'b0 : t[8]; end
      4'd9: begin t = ua >> n; e.res = t[7:0];
                  t = (n == 0) ? 0 : ((ua >> (n - 1)) & 1); e.c = t[0]; end
      4'd10: begin t = ua * ub; e.res = t[7:0]; e.c = (t > 255); end
      default: ;
    endcase
    e.z = (e.res == 8'd0);
    return e;
  endfunction

  // Scoreboard: a transfer happens at the posedge following a negedge with valid&&ready.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", 32'(result), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        $display("TX cyc=%0d res=%02h c=%b z=%b o=%b exp_res=%02h", cyc, result, Cout, zero, ovf, e.res);
        check_eq("sb", 32'({result, Cout, zero, ovf}), 32'(e));
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int waited);
    waited = 0;
    in_valid = 1'b1; sel = op; A = a; B = b;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 1);
    else sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; in-flight ops must not notice.
    in_valid = 1'b0; sel = 4'($urandom); A = 8'($urandom); B = 8'($urandom);
  endtask

  task automatic op4(input string tag, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] er, input logic ec, input logic eo);
    sel4 = op; a4 = a; b4 = b; in_valid4 = 1'b1;
    check_eq({tag, "_rdy"}, 32'(in_ready4), 1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    $display("TX4 %s res=%b c=%b z=%b o=%b", tag, res4, c4, z4, o4);
    check_eq(tag, 32'({out_valid4, res4, c4, z4, o4}), 32'({1'b1, er, ec, (er == 4'd0), eo}));
  endtask

  initial begin
    int   n, k, nsum, gap;
    logic stable, rdy_seen, ov_seen;
    in_valid = 0; sel = 0; A = 0; B = 0; out_ready = 1;
    in_valid4 = 0; sel4 = 0; a4 = 0; b4 = 0; out_ready4 = 1;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_outs", 32'({out_valid, in_ready, result, Cout, zero, ovf}), 0);
    check_eq("rst_outs4", 32'({out_valid4, in_ready4}), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_eq("rdy_after_rst", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    op4("add4",  OP_ADD, 4'b1010, 4'b0101, 4'b1111, 1'b0, 1'b0);
    op4("sub4a", OP_SUB, 4'b1100, 4'b0011, 4'b1001, 1'b1, 1'b0);
    op4("sub4b", OP_SUB, 4'b0111, 4'b1000, 4'b1111, 1'b0, 1'b1);

    // MUL latency and input blocking
    send(OP_MUL, 8'd15, 8'd17, n);
    rdy_seen = 0; k = 0;
    while (!out_valid && k < 30) begin
      @(posedge clk); #1; k++;
      if (!out_valid) rdy_seen |= in_ready;
    end
    check_eq("mul_lat_a", k, 9);
    check_eq("mul_rdy_a", 32'(rdy_seen), 0);
    send(OP_MUL, 8'd16, 8'd16, n);
    rdy_seen = 0; k = 0;
    while (!out_valid && k < 30) begin
      @(posedge clk); #1; k++;
      if (!out_valid) rdy_seen |= in_ready;
    end
    check_eq("mul_lat_b", k, 9);
    check_eq("mul_rdy_b", 32'(rdy_seen), 0);

    // Backpressure hold
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(OP_XOR, 8'hAA, 8'hCC, n);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      stable &= (out_valid && result == 8'h66 && !in_ready && !Cout && !zero && !ovf);
    end
    check_eq("hold_stable", 32'(stable), 1);
    out_ready = 1'b1;
    send(OP_ADD, 8'h10, 8'h20, n);
    check_eq("hold_release", n, 0);

    // Back-to-back logic-op stream
    repeat (3) @(posedge clk);
    #1 xfer_cyc.delete();
    nsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(4'(OP_AND + 4'(i % 6)), 8'($urandom), 8'($urandom), n);
      nsum += n;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("stream_waits", nsum, 0);
    check_eq("stream_count", xfer_cyc.size(), 8);
    gap = (xfer_cyc.size() > 0) ? (xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[0]) : -1;
    check_eq("stream_gap", gap, 7);

    // Mixed random traffic, including shifts, reserved codes and MUL
    for (int i = 0; i < 24; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), n);
    end
    send(OP_SHL, 8'h81, 8'd0, n);
    send(OP_SHR, 8'h81, 8'd1, n);
    send(OP_SHL, 8'h81, 8'd1, n);

    // Reset in the middle of a multiply
    send(OP_ADD, 8'd1, 8'd2, n);
    send(OP_MUL, 8'd5, 8'd7, n);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_mid", 32'({out_valid, in_ready, result, Cout, zero, ovf}), 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_eq("rdy_after_rst2", 32'(in_ready), 1);
    ov_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      ov_seen |= out_valid;
    end
    check_eq("no_stale", 32'(ov_seen), 0);
    send(4'd12, 8'h5A, 8'h3C, n);

    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(posedge clk); k++;
    end
    #1 check_eq("drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 Parameter: MUL_EN, default 1, includes the iterative multiply opcode when 1.
REQ-003 Port: clk  input  1  single clock, rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  operand/opcode presented.
REQ-006 Port: in_ready  output  1  block accepts operands this cycle.
REQ-007 Port: A, B  input  WIDTH  operands, unsigned for logic/MUL, two's-complement for overflow flag.
REQ-008 Port: sel  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR, 7 XNOR, 8 SHL, 9 SHR, 10 MUL, 11-15 reserved.
REQ-009 Port: out_valid  output  1  result/flags valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: result  output  WIDTH  operation result.
REQ-012 Port: Cout  output  1  carry (ADD), no-borrow (SUB), last bit shifted out (SHL/SHR), upper-half-nonzero (MUL), else 0.
REQ-013 Port: zero, ovf  output  1 each  result==0; signed overflow (ADD/SUB only, else 0).

Function
REQ-014 Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
REQ-015 FSM states IDLE, MUL, HOLD; IDLE->MUL on accepted MUL; MUL->HOLD after WIDTH iterations; HOLD->IDLE on output transfer.
REQ-016 in_ready SHALL be 1 only in IDLE and when (!out_valid || out_ready), permitting back-to-back single-cycle ops at full throughput.
REQ-017 Non-MUL ops: result/flags registered, out_valid asserted the cycle after acceptance (latency 1).
REQ-018 SUB SHALL compute A + ~B + 1 over WIDTH+1 bits; Cout = bit WIDTH.
REQ-019 SHL/SHR: shift A by B[log2(WIDTH)-1:0], zero fill; shift by 0 gives Cout=0.
REQ-020 MUL: shift-add, one bit per cycle, WIDTH cycles; result = low WIDTH bits of A*B; out_valid at acceptance+WIDTH+1; in_ready=0 throughout.
REQ-021 Reserved opcodes or MUL with MUL_EN=0: result=0, Cout=0, ovf=0, zero=1, latency 1.
REQ-022 While out_valid && !out_ready, result and all flags SHALL hold stable; no new input accepted.
REQ-023 Operands SHALL be captured at acceptance; later changes on A/B/sel have no effect on the in-flight op.
REQ-024 Simultaneous output transfer and new input acceptance in the same cycle SHALL replace the output with the new op's result next cycle, no bubble.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, Cout=0, zero=0, ovf=0, multiplier counter/accumulator=0.
REQ-026 Reset mid-MUL SHALL abandon the operation; no result is emitted after release.
REQ-027 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.

Structure
REQ-028 Package alu_pkg SHALL hold opcode constants, FSM state encoding, and flag bit positions.
REQ-029 Sub-module alu_mul_seq (start, A, B -> done, product low/high-nonzero) SHALL implement the iterative multiplier; the remainder is single-module.

Verification
REQ-030 WIDTH=4: ADD A=1010 B=0101 -> result 1111, Cout 0, zero 0, ovf 0, out_valid 1 cycle later.
REQ-031 WIDTH=4: SUB A=1100 B=0011 -> result 1001, Cout 1; SUB A=0111 B=1000 -> result 1111, ovf 1.
REQ-032 WIDTH=8: MUL 15*17 -> result 0xFF, Cout 0 at cycle +9; MUL 16*16 -> result 0x00, Cout 1, zero 1; in_ready 0 throughout.
REQ-033 Hold out_ready=0 for 5 cycles after XOR 0xAA^0xCC -> result 0x66 stable, in_ready 0; release -> next op accepted same cycle.
REQ-034 Stream 8 logic ops (AND..XNOR) with out_ready=1 -> 8 results on 8 consecutive cycles, no bubbles, values match golden model.
REQ-035 Assert rst_n=0 at cycle 3 of a MUL -> all outputs 0 immediately; after release, no stale out_valid; sel=12 -> result 0, zero 1.
